// File: rtl/fetch_queue.sv
// Fetch-block buffer between the PC-driven fetch stage and decode.
// In-order circular queue with a wrap-bit pointer pair, stall back-pressure and flush.
module fetch_queue #(
  parameter int DEPTH       = 4,
  parameter int SKID        = 1,
  parameter int PC_WIDTH    = 32,
  parameter int BLOCK_WIDTH = 64
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_flush,
  input  logic                     i_valid,
  input  logic [PC_WIDTH-1:0]      i_pc,
  input  logic [BLOCK_WIDTH-1:0]   i_data,
  output logic                     o_stall,
  output logic                     o_valid,
  output logic [PC_WIDTH-1:0]      o_pc,
  output logic [BLOCK_WIDTH-1:0]   o_data,
  input  logic                     i_ready,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int EW = PC_WIDTH + BLOCK_WIDTH;
  localparam logic [PW-1:0] STALL_TH = PW'(DEPTH - SKID);

  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic          r_overflow;
  logic [EW-1:0] r_mem [DEPTH];

  logic [PW-1:0] w_count;
  logic          w_empty;
  logic          w_full;
  logic          w_deq;
  logic          w_enq;
  logic [EW-1:0] w_head_entry;

  assign w_count = r_tail - r_head;
  assign w_empty = (r_head == r_tail);
  assign w_full  = (r_head[AW-1:0] == r_tail[AW-1:0]) && (r_head[AW] != r_tail[AW]);
  assign w_deq   = ~w_empty & i_ready;
  assign w_enq   = i_valid & (~w_full | w_deq);

  // Control state: pointers and the sticky overflow flag.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_head     <= '0;
      r_tail     <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (i_valid && w_full && !w_deq)
        r_overflow <= 1'b1;
      if (i_flush) begin
        r_head <= '0;
        r_tail <= '0;
      end else begin
        if (w_deq) r_head <= r_head + PW'(1);
        if (w_enq) r_tail <= r_tail + PW'(1);
      end
    end
  end

  // Storage is data only; entries beyond the pointers are never observed.
  always_ff @(posedge i_clk) begin
    if (w_enq && !i_flush && !i_rst)
      r_mem[r_tail[AW-1:0]] <= {i_pc, i_data};
  end

  assign w_head_entry = r_mem[r_head[AW-1:0]];

  assign o_valid    = ~w_empty;
  assign o_pc       = w_head_entry[EW-1:BLOCK_WIDTH];
  assign o_data     = w_head_entry[BLOCK_WIDTH-1:0];
  assign o_count    = w_count;
  assign o_stall    = (w_count >= STALL_TH);
  assign o_overflow = r_overflow;

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue (DEPTH=4, SKID=1): expected blocks are queued
// as they are offered and compared against the head whenever decode takes one.
module tb_fetch_queue;

  localparam int DEPTH = 4;
  localparam int SKID  = 1;

  logic        clk = 1'b0;
  logic        rst, flush, valid, ready;
  logic [31:0] pc;
  logic [63:0] data;
  logic        stall, ovalid, overflow;
  logic [31:0] opc;
  logic [63:0] odata;
  logic [2:0]  count;

  int n_tests = 0;
  int n_fail  = 0;
  int n_pop   = 0;

  logic [95:0] sb[$];
  logic        m_ovf = 1'b0;

  fetch_queue #(.DEPTH(DEPTH), .SKID(SKID), .PC_WIDTH(32), .BLOCK_WIDTH(64)) dut (
    .i_clk(clk), .i_rst(rst), .i_flush(flush), .i_valid(valid), .i_pc(pc),
    .i_data(data), .o_stall(stall), .o_valid(ovalid), .o_pc(opc), .o_data(odata),
    .i_ready(ready), .o_count(count), .o_overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] blk(input logic [31:0] p);
    return {~p, p ^ 32'h5a5a_0000};
  endfunction

  // One clock: drive, check outputs against the model at negedge, update model, advance.
  task automatic cyc(input logic v, input logic [31:0] p, input logic rdy,
                     input logic fl, input logic rs);
    int  sz;
    logic m_deq, m_full;
    valid = v; pc = p; data = blk(p); ready = rdy; flush = fl; rst = rs;
    @(negedge clk);
    sz = sb.size();
    check("valid", {63'd0, ovalid}, {63'd0, sz != 0});
    check("count", {61'd0, count}, 64'(sz));
    check("stall", {63'd0, stall}, {63'd0, sz >= DEPTH - SKID});
    check("ovf",   {63'd0, overflow}, {63'd0, m_ovf});
    if (sz != 0) begin
      check("head_pc",   {32'd0, opc}, {32'd0, sb[0][95:64]});
      check("head_data", odata, sb[0][63:0]);
    end
    m_deq  = (sz != 0) && rdy;
    m_full = (sz == DEPTH);
    if (rs) begin
      sb.delete();
      m_ovf = 1'b0;
    end else begin
      if (v && m_full && !m_deq) m_ovf = 1'b1;
      if (fl) sb.delete();
      else begin
        if (m_deq) begin
          void'(sb.pop_front());
          n_pop++;
        end
        if (v && (!m_full || m_deq)) sb.push_back({p, blk(p)});
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int pops0;
    rst = 1'b1; flush = 1'b0; valid = 1'b0; ready = 1'b0; pc = '0; data = '0;
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);
    check("rst_count", {61'd0, count}, 64'd0);
    check("rst_valid", {63'd0, ovalid}, 64'd0);
    check("rst_stall", {63'd0, stall}, 64'd0);
    check("rst_ovf",   {63'd0, overflow}, 64'd0);

    // Fill to threshold with decode stalled.
    cyc(1, 32'h100, 0, 0, 0);
    check("fill1_count", {61'd0, count}, 64'd1);
    cyc(1, 32'h108, 0, 0, 0);
    check("fill2_stall", {63'd0, stall}, 64'd0);
    cyc(1, 32'h110, 0, 0, 0);
    check("fill3_count", {61'd0, count}, 64'd3);
    check("fill3_stall", {63'd0, stall}, 64'd1);
    check("fill3_pc",    {32'd0, opc}, 64'h100);

    // Full, then simultaneous enqueue/dequeue, then drain.
    cyc(1, 32'h118, 0, 0, 0);
    check("full_count", {61'd0, count}, 64'd4);
    cyc(1, 32'h120, 1, 0, 0);
    check("simul_count", {61'd0, count}, 64'd4);
    check("simul_ovf",   {63'd0, overflow}, 64'd0);
    check("simul_pc",    {32'd0, opc}, 64'h108);
    repeat (4) cyc(0, 0, 1, 0, 0);
    check("drain_valid", {63'd0, ovalid}, 64'd0);

    // Overflow and its survival across a flush.
    for (int i = 0; i < 4; i++) cyc(1, 32'h300 + 32'(8 * i), 0, 0, 0);
    cyc(1, 32'h320, 0, 0, 0);
    check("ovf_count", {61'd0, count}, 64'd4);
    check("ovf_set",   {63'd0, overflow}, 64'd1);
    cyc(0, 0, 0, 1, 0);
    check("ovf_after_flush", {63'd0, overflow}, 64'd1);
    check("flush_count",     {61'd0, count}, 64'd0);

    // Streaming through the wrap points.
    pops0 = n_pop;
    for (int i = 0; i < 12; i++) cyc(1, 32'h400 + 32'(8 * i), 1, 0, 0);
    cyc(0, 0, 1, 0, 0);
    check("stream_pops", 64'(n_pop - pops0), 64'd12);
    check("stream_empty", {63'd0, ovalid}, 64'd0);

    // Flush with a block offered and decode ready.
    for (int i = 0; i < 3; i++) cyc(1, 32'h480 + 32'(8 * i), 0, 0, 0);
    cyc(1, 32'h500, 1, 1, 0);
    check("fl_valid", {63'd0, ovalid}, 64'd0);
    check("fl_count", {61'd0, count}, 64'd0);
    check("fl_stall", {63'd0, stall}, 64'd0);
    cyc(1, 32'h200, 0, 0, 0);
    check("fl_next_pc",    {32'd0, opc}, 64'h200);
    check("fl_next_valid", {63'd0, ovalid}, 64'd1);

    // Reset in the middle of operation.
    cyc(1, 32'h208, 0, 0, 0);
    cyc(1, 32'h210, 0, 0, 1);
    check("mrst_count", {61'd0, count}, 64'd0);
    check("mrst_valid", {63'd0, ovalid}, 64'd0);
    check("mrst_ovf",   {63'd0, overflow}, 64'd0);
    cyc(0, 0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
